// File: rtl/laser_frame_receiver.sv
// Dual-lane optical frame receiver: 8N1 frames on two bit-aligned lanes, handshaked byte-pair output.
// Optional LASER_RX_MAJORITY_EN: 2-of-3 majority vote on each bit sample.
module laser_frame_receiver #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       laser1_in,
   input  logic       laser2_in,
   input  logic       rx_ready,
   output logic [7:0] data1_out,
   output logic [7:0] data2_out,
   output logic       rx_valid,
   output logic       frame_error,
   output logic       overrun
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = 3;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t state, state_next;

   logic l1_s1, l1_s2, l2_s1, l2_s2;
   logic l1_prev, l2_prev;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [BYTE_W-1:0] shift1, shift2;

   logic samp1_c, samp2_c;
   logic start_edge_c, mid_c, last_c;
   logic cnt_clear_c, shift_c, frame_good_c, frame_bad_c;

   // Two-flop synchronizers plus previous-value register for falling-edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         l1_s1   <= 1'b1;
         l1_s2   <= 1'b1;
         l2_s1   <= 1'b1;
         l2_s2   <= 1'b1;
         l1_prev <= 1'b1;
         l2_prev <= 1'b1;
      end else begin
         l1_s1   <= laser1_in;
         l1_s2   <= l1_s1;
         l2_s1   <= laser2_in;
         l2_s2   <= l2_s1;
         l1_prev <= l1_s2;
         l2_prev <= l2_s2;
      end
   end

`ifdef LASER_RX_MAJORITY_EN
   logic l1_h1, l1_h2, l2_h1, l2_h2;

   // Two older synchronized values per lane; vote spans the last three
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         l1_h1 <= 1'b1;
         l1_h2 <= 1'b1;
         l2_h1 <= 1'b1;
         l2_h2 <= 1'b1;
      end else begin
         l1_h1 <= l1_s2;
         l1_h2 <= l1_h1;
         l2_h1 <= l2_s2;
         l2_h2 <= l2_h1;
      end
   end

   assign samp1_c = (l1_s2 & l1_h1) | (l1_s2 & l1_h2) | (l1_h1 & l1_h2);
   assign samp2_c = (l2_s2 & l2_h1) | (l2_s2 & l2_h2) | (l2_h1 & l2_h2);
`else
   assign samp1_c = l1_s2;
   assign samp2_c = l2_s2;
`endif

   assign start_edge_c = (l1_prev & ~l1_s2) | (l2_prev & ~l2_s2);
   assign mid_c        = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
   assign last_c       = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start_edge_c) state_next = START;
         START: if (mid_c) state_next = (!samp1_c && !samp2_c) ? DATA : IDLE;
         DATA:  if (last_c && bit_idx == IDX_W'(7)) state_next = STOP;
         STOP:  if (last_c) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Per-state control strobes for the datapath
   always_comb begin
      cnt_clear_c  = 1'b0;
      shift_c      = 1'b0;
      frame_good_c = 1'b0;
      frame_bad_c  = 1'b0;
      case (state)
         IDLE:  cnt_clear_c = 1'b1;
         START: cnt_clear_c = mid_c;
         DATA: begin
            cnt_clear_c = last_c;
            shift_c     = last_c;
         end
         STOP: begin
            cnt_clear_c  = last_c;
            frame_good_c = last_c & samp1_c & samp2_c;
            frame_bad_c  = last_c & ~(samp1_c & samp2_c);
         end
         default: cnt_clear_c = 1'b1;
      endcase
   end

   // Counters, shift registers and the output holding stage
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         bit_idx     <= '0;
         shift1      <= '0;
         shift2      <= '0;
         data1_out   <= '0;
         data2_out   <= '0;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         cnt <= cnt_clear_c ? '0 : cnt + CNT_W'(1);

         if (state == IDLE) bit_idx <= '0;
         else if (shift_c)  bit_idx <= bit_idx + IDX_W'(1);

         if (shift_c) begin
            shift1 <= {samp1_c, shift1[BYTE_W-1:1]};
            shift2 <= {samp2_c, shift2[BYTE_W-1:1]};
         end

         frame_error <= frame_bad_c;
         overrun     <= 1'b0;

         // A completing frame loads if the slot is empty or being taken this edge
         if (frame_good_c) begin
            if (!rx_valid || rx_ready) begin
               data1_out <= shift1;
               data2_out <= shift2;
               rx_valid  <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
